// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_arbiter: FSM state encoding, owner ids and counter width.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RESP   = 3'd2,
    DUMP   = 3'd3,
    HALTED = 3'd4
  } state_e;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

endpackage

// File: rtl/mem_lat_counter.sv
// Load/clear down-counter timing the ACCESS phase; is_last flags the final cycle.
module mem_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             is_last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_last = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory2c-style memory between IF (read-only) and MEM (read/write) and sequences the halt dump.
// Optional macro MEM_ALIGN_CHECK_EN: odd addresses skip the memory, return 0 and pulse err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_done,
  input  logic        halt,
  output logic        m_enable,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  input  logic [15:0] m_data_out,
  output logic        m_createdump,
  output logic        halted,
  output logic        err
);

  localparam logic [CNT_W-1:0] LAT_V    = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] STARVE_V = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             lat_load, lat_clr, lat_dec, lat_last;
  logic             grant_if;
`ifdef MEM_ALIGN_CHECK_EN
  logic             err_q, err_d;
`endif

  // IF overrides MEM priority only once MEM has won STARVE_LIMIT times in a row against a waiting IF.
  assign grant_if = if_req && (!mem_req || (starve_q == STARVE_V));
  assign lat_dec  = (state_q == ACCESS);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    starve_d = starve_q;
    lat_load = 1'b0;
    lat_clr  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = DUMP;
        end else if (if_req || mem_req) begin
          owner_d  = grant_if ? OWN_IF : OWN_MEM;
          addr_d   = grant_if ? if_addr : mem_addr;
          wr_d     = grant_if ? 1'b0 : mem_wr;
          wdata_d  = mem_wdata;
          if (grant_if || !if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_V) begin
            starve_d = starve_q + 1'b1;
          end
          lat_load = 1'b1;
          state_d  = ACCESS;
`ifdef MEM_ALIGN_CHECK_EN
          err_d = 1'b0;
          if (addr_d[0]) begin
            err_d    = 1'b1;
            rdata_d  = '0;
            lat_load = 1'b0;
            state_d  = RESP;
          end
`endif
        end
      end
      ACCESS: begin
        if (lat_last) begin
          if (!wr_q) begin
            rdata_d = m_data_out;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        lat_clr = 1'b1;
        state_d = IDLE;
      end
      DUMP:    state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = (state_q == RESP) && err_q;
`else
  assign err = 1'b0;
`endif

  mem_lat_counter #(.CNT_W(CNT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .clr      (lat_clr),
    .dec      (lat_dec),
    .load_val (LAT_V),
    .is_last  (lat_last)
  );

  // Write strobe only on the last ACCESS cycle so the memory sees a single write edge.
  assign m_enable     = (state_q == ACCESS);
  assign m_wr         = m_enable && wr_q && lat_last;
  assign m_addr       = addr_q;
  assign m_data_in    = wdata_q;
  assign m_createdump = (state_q == DUMP);
  assign halted       = (state_q == HALTED);
  assign if_done      = (state_q == RESP) && (owner_q == OWN_IF);
  assign mem_done     = (state_q == RESP) && (owner_q == OWN_MEM);
  assign if_rdata     = if_done  ? rdata_q : '0;
  assign mem_rdata    = mem_done ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a behavioural memory and reference model.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam int SL  = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_wr = 1'b0, halt = 1'b0;
  logic [15:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [15:0] if_rdata, mem_rdata, m_addr, m_data_in, m_data_out;
  logic        if_done, mem_done, m_enable, m_wr, m_createdump, halted, err;

  logic        b_rst = 1'b1, b_mem_req = 1'b0, b_mem_wr = 1'b0;
  logic [15:0] b_mem_addr = '0, b_mem_wdata = '0;
  logic [15:0] b_if_rdata, b_mem_rdata, b_m_addr, b_m_data_in;
  logic        b_if_done, b_mem_done, b_m_enable, b_m_wr, b_m_createdump, b_halted, b_err;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .halt(halt),
    .m_enable(m_enable), .m_wr(m_wr), .m_addr(m_addr), .m_data_in(m_data_in),
    .m_data_out(m_data_out), .m_createdump(m_createdump), .halted(halted), .err(err)
  );

  mem_arbiter #(.LATENCY(3), .STARVE_LIMIT(SL)) u_dut3 (
    .clk(clk), .rst(b_rst),
    .if_req(1'b0), .if_addr(16'h0000), .if_rdata(b_if_rdata), .if_done(b_if_done),
    .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_done(b_mem_done), .halt(1'b0),
    .m_enable(b_m_enable), .m_wr(b_m_wr), .m_addr(b_m_addr), .m_data_in(b_m_data_in),
    .m_data_out(16'hA5A5), .m_createdump(b_m_createdump), .halted(b_halted), .err(b_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory contents before any write: a recognisable function of the address.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  logic [15:0] mem [0:65535];
  int          wr_cnt = 0;
  int          b_wr_cnt = 0;
  assign m_data_out = mem[m_addr];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    forever begin
      @(posedge clk);
      if (m_enable && m_wr) begin
        mem[m_addr] = m_data_in;
        wr_cnt++;
      end
      if (b_m_enable && b_m_wr) b_wr_cnt++;
    end
  end

  // Reference model: expected response of one transaction from the memory's logical contents.
  typedef struct packed {
    logic [15:0] rdata;
    logic        chk;
    logic        err;
  } exp_t;

  logic [15:0] ref_mem [int];
  exp_t        if_q[$];
  exp_t        mem_q[$];
  logic        gl[$];
  bit          log_en = 1'b0;

  function automatic exp_t model(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    exp_t e;
    e = '0;
    if (ALIGN && a[0]) begin
      e.chk = 1'b1;
      e.err = 1'b1;
    end else if (wr) begin
      ref_mem[int'(a)] = wd;
    end else begin
      e.chk   = 1'b1;
      e.rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    end
    return e;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (if_done && mem_done) chk("both_done", 1, 0);
      if (mem_done) begin
        if (mem_q.size() == 0) chk("mem_done_unexpected", 1, 0);
        else begin
          mon_e = mem_q.pop_front();
          if (mon_e.chk) chk("mem_rdata", mem_rdata, mon_e.rdata);
          chk("mem_err", err, mon_e.err);
          if (log_en) gl.push_back(1'b1);
        end
      end
      if (if_done) begin
        if (if_q.size() == 0) chk("if_done_unexpected", 1, 0);
        else begin
          mon_e = if_q.pop_front();
          if (mon_e.chk) chk("if_rdata", if_rdata, mon_e.rdata);
          chk("if_err", err, mon_e.err);
          if (log_en) gl.push_back(1'b0);
        end
      end
      if (err && !if_done && !mem_done) chk("err_without_done", 1, 0);
`ifdef MEM_ALIGN_CHECK_EN
      if (m_enable && m_addr[0]) chk("unaligned_reached_memory", 1, 0);
`endif
    end
  end

  task automatic mem_txn(input logic wr, input logic [15:0] a, input logic [15:0] wd, input bit hold);
    int t;
    mem_q.push_back(model(wr, a, wd));
    mem_wr = wr; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!mem_done && t < 400);
    if (!mem_done) chk("mem_done_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) mem_req = 1'b0;
  endtask

  task automatic if_txn(input logic [15:0] a, input bit hold);
    int t;
    if_q.push_back(model(1'b0, a, 16'h0000));
    if_addr = a; if_req = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!if_done && t < 400);
    if (!if_done) chk("if_done_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) if_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  en_v, dn_v, wr_v, er_v;
    logic        ifd;
    logic [15:0] rd;
    int          w0, cd_cnt, hd_dump, bad;

    #1;
    chk("reset_ctrl", {if_done, mem_done, m_enable, m_wr, m_createdump, halted, err}, 7'b0);
    chk("reset_data", {if_rdata, mem_rdata, m_addr, m_data_in}, 64'h0);
    idle(2);
    rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {m_enable, m_createdump, halted, if_done, mem_done}, 5'b0);
    @(posedge clk); #1;

    // Single read of preloaded word.
    mem_q.push_back(model(1'b0, 16'h0010, 16'h0000));
    mem_wr = 1'b0; mem_addr = 16'h0010; mem_req = 1'b1;
    ifd = 1'b0; rd = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      en_v[c] = m_enable; dn_v[c] = mem_done; ifd |= if_done;
      if (mem_done) rd = mem_rdata;
    end
    @(posedge clk); #1 mem_req = 1'b0;
    chk("read_enable_cycles", en_v, 4'b0110);
    chk("read_done_cycle", dn_v, 4'b1000);
    chk("read_if_done", ifd, 1'b0);
    chk("read_rdata", rd, 16'hBEEF);

    // Write, then read back.
    idle(1);
    w0 = wr_cnt;
    mem_q.push_back(model(1'b1, 16'h0020, 16'h1234));
    mem_wr = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h1234; mem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      wr_v[c] = m_wr; dn_v[c] = mem_done;
    end
    @(posedge clk); #1 mem_req = 1'b0;
    chk("write_strobe_cycles", wr_v, 4'b0100);
    chk("write_done_cycle", dn_v, 4'b1000);
    chk("write_edge_count", wr_cnt - w0, 1);
    mem_txn(1'b0, 16'h0020, 16'h0000, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    // Unaligned read bypasses the memory.
    mem_q.push_back(model(1'b0, 16'h0011, 16'h0000));
    mem_wr = 1'b0; mem_addr = 16'h0011; mem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      en_v[c] = m_enable; dn_v[c] = mem_done; er_v[c] = err;
    end
    mem_req = 1'b0;
    chk("align_no_enable", en_v, 4'b0000);
    chk("align_done_cycle", dn_v, 4'b0010);
    chk("align_err_with_done", er_v, 4'b0010);
    idle(1);
`endif

    // Random interleaved traffic from both requesters.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          idle($urandom_range(0, 3));
          mem_txn(1'($urandom), {8'h00, 8'($urandom)}, 16'($urandom), 1'b0);
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          idle($urandom_range(0, 3));
          if_txn({8'h10, 8'($urandom)}, 1'b0);
        end
      end
    join
    idle(2);
    chk("random_mem_q_drained", mem_q.size(), 0);
    chk("random_if_q_drained", if_q.size(), 0);

    // Both requesters held continuously: starvation guard pattern.
    pulse_reset();
    log_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) mem_txn(1'b0, {8'h00, 8'(2 * i)}, 16'h0000, i < 9);
      end
      begin
        for (int i = 0; i < 3; i++) if_txn({8'h10, 8'(4 * i)}, i < 2);
      end
    join
    log_en = 1'b0;
    chk("contention_grants", gl.size(), 13);
    for (int k = 0; k < 12 && k < gl.size(); k++)
      chk($sformatf("grant_%0d_is_mem", k), gl[k], (k % (SL + 1)) != SL);

    // Halt raised during a write.
    idle(1);
    fork
      mem_txn(1'b1, 16'h0030, 16'hC0DE, 1'b0);
      begin @(posedge clk); #1 halt = 1'b1; end
    join
    cd_cnt = 0; hd_dump = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_createdump) begin cd_cnt++; hd_dump = halted; end
    end
    chk("dump_one_cycle", cd_cnt, 1);
    chk("halted_low_during_dump", hd_dump, 0);
    chk("halted_high", halted, 1'b1);
    chk("halt_write_landed", mem[16'h0030], 16'hC0DE);
    @(posedge clk); #1 if_addr = 16'h1000; if_req = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_done || m_enable || m_wr || m_createdump || !halted) bad++;
    end
    chk("halted_ignores_requests", bad, 0);
    if_req = 1'b0; halt = 1'b0;
    pulse_reset();
    mem_txn(1'b0, 16'h0030, 16'h0000, 1'b0);

    // Reset in the first ACCESS cycle of a LATENCY=3 write.
    @(posedge clk); #1;
    b_mem_wr = 1'b1; b_mem_addr = 16'h0040; b_mem_wdata = 16'hDEAD; b_mem_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_enable_before_reset", b_m_enable, 1'b1);
    b_rst = 1'b1;
    #1;
    chk("abort_ctrl_zero", {b_if_done, b_mem_done, b_m_enable, b_m_wr, b_m_createdump, b_halted, b_err}, 7'b0);
    chk("abort_data_zero", {b_if_rdata, b_mem_rdata, b_m_addr, b_m_data_in}, 64'h0);
    b_mem_req = 1'b0;
    @(posedge clk); @(posedge clk); #1 b_rst = 1'b0;
    bad = 0;
    repeat (8) begin @(negedge clk); if (b_mem_done || b_if_done) bad++; end
    chk("abort_no_done", bad, 0);
    chk("abort_no_write", b_wr_cnt, 0);

    idle(2);
    chk("final_mem_q_drained", mem_q.size(), 0);
    chk("final_if_q_drained", if_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
